// File: rtl/zoom_2x_frame_sequencer.sv
// zoom_2x_frame_sequencer
// Walks the SRC_W x SRC_H source image in raster order. Each source pixel is
// read once and written to the four framebuffer locations of its 2x2 block.
//
// Handshakes:
//   src RAM     : src_rd_en is a one-cycle read strobe; src_rd_data is valid
//                 in the following cycle (1-cycle synchronous RAM).
//   framebuffer : dst_wr_en acts as valid and dst_wr_ready as ready. A write
//                 transfers on a rising edge where both are high. While valid is
//                 high and ready is low, dst_wr_addr, dst_wr_data and quad_idx
//                 are held stable. dst_wr_ready is ignored outside WR.
//   host        : start is sampled only in IDLE. busy covers RD_ADDR..DONE.
//                 done pulses for one cycle after the last write is accepted.
module zoom_2x_frame_sequencer #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_data,
    output logic              dst_wr_en,
    output logic [DST_AW-1:0] dst_wr_addr,
    output logic [7:0]        dst_wr_data,
    input  logic              dst_wr_ready,
    output logic [1:0]        quad_idx,
    output logic [2:0]        dbg_state_o
);

    localparam int COL_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int ROW_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SRC_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(SRC_H - 1);
    // One destination line is twice the source width.
    localparam logic [DST_AW-1:0] DST_LINE = DST_AW'(2 * SRC_W);
    // Moving from the last block of a row to the first block of the next row
    // skips the odd destination line: base goes from 4W*r + 2(W-1) to 4W*(r+1).
    localparam logic [DST_AW-1:0] DST_WRAP = DST_AW'(2 * SRC_W + 2);
    localparam logic [DST_AW-1:0] DST_STEP = DST_AW'(2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic [ROW_W-1:0]    row_q;
    logic [COL_W-1:0]    col_q;
    logic [1:0]          quad_q;
    logic [DST_AW-1:0]   dst_base_q;     // address of quadrant 0 of the current block
    logic                busy_q;
    logic                done_q;
    logic                src_rd_en_q;
    logic [SRC_AW-1:0]   src_addr_q;     // doubles as the raster pixel counter
    logic                dst_wr_en_q;
    logic [DST_AW-1:0]   dst_addr_q;
    logic [7:0]          pix_q;

    logic [1:0]          quad_d;
    logic [DST_AW-1:0]   dst_quad_addr_d;
    logic                last_pixel_d;

    // Next quadrant index and its destination address within the current block.
    always_comb begin
        quad_d          = quad_q + 2'd1;
        dst_quad_addr_d = dst_base_q
                        + (quad_d[1] ? DST_LINE : '0)
                        + {{(DST_AW-1){1'b0}}, quad_d[0]};
        last_pixel_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end

    // Frame FSM: raster walk, read-then-four-writes per pixel, registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            quad_q      <= '0;
            dst_base_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            src_rd_en_q <= 1'b0;
            src_addr_q  <= '0;
            dst_wr_en_q <= 1'b0;
            dst_addr_q  <= '0;
            pix_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        row_q       <= '0;
                        col_q       <= '0;
                        quad_q      <= '0;
                        dst_base_q  <= '0;
                        src_addr_q  <= '0;
                        src_rd_en_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_RD_ADDR;
                    end
                end
                S_RD_ADDR: begin
                    src_rd_en_q <= 1'b0;
                    state_q     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    pix_q       <= src_rd_data;
                    quad_q      <= '0;
                    dst_addr_q  <= dst_base_q;
                    dst_wr_en_q <= 1'b1;
                    state_q     <= S_WR;
                end
                S_WR: begin
                    if (dst_wr_ready) begin
                        if (quad_q != 2'd3) begin
                            quad_q     <= quad_d;
                            dst_addr_q <= dst_quad_addr_d;
                        end else begin
                            dst_wr_en_q <= 1'b0;
                            if (last_pixel_d) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                if (col_q == COL_LAST) begin
                                    col_q      <= '0;
                                    row_q      <= row_q + 1'b1;
                                    dst_base_q <= dst_base_q + DST_WRAP;
                                end else begin
                                    col_q      <= col_q + 1'b1;
                                    dst_base_q <= dst_base_q + DST_STEP;
                                end
                                src_addr_q  <= src_addr_q + 1'b1;
                                src_rd_en_q <= 1'b1;
                                state_q     <= S_RD_ADDR;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    src_rd_en_q <= 1'b0;
                    dst_wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign src_rd_en   = src_rd_en_q;
    assign src_rd_addr = src_addr_q;
    assign dst_wr_en   = dst_wr_en_q;
    assign dst_wr_addr = dst_addr_q;
    assign dst_wr_data = pix_q;
    assign quad_idx    = quad_q;
    assign dbg_state_o = state_q;

endmodule
